// File: rtl/keyboard_pkg.sv
// Shared key codes, scan-code prefixes, parser states and event payload for keyboard_events.
package keyboard_pkg;

  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_ESC   = 3'd1;
  localparam logic [2:0] KEY_SPACE = 3'd2;
  localparam logic [2:0] KEY_UP    = 3'd3;
  localparam logic [2:0] KEY_DOWN  = 3'd4;
  localparam logic [2:0] KEY_LEFT  = 3'd5;
  localparam logic [2:0] KEY_RIGHT = 3'd6;
  localparam logic [2:0] KEY_OTHER = 3'd7;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] code;
    logic       make;
    logic       rpt;
  } kb_event_t;

  // Map a scan byte to a logical key; extended codes only know the arrow cluster.
  function automatic logic [2:0] decode_key(input logic [7:0] sc, input logic ext);
    logic [2:0] k;
    k = KEY_OTHER;
    if (ext) begin
      case (sc)
        8'h75:   k = KEY_UP;
        8'h72:   k = KEY_DOWN;
        8'h6B:   k = KEY_LEFT;
        8'h74:   k = KEY_RIGHT;
        default: k = KEY_OTHER;
      endcase
    end else begin
      case (sc)
        8'h76:               k = KEY_ESC;
        8'h29:               k = KEY_SPACE;
        8'h1D, 8'h42, 8'h75: k = KEY_UP;
        8'h1B, 8'h3B, 8'h72: k = KEY_DOWN;
        8'h1C, 8'h33, 8'h6B: k = KEY_LEFT;
        8'h23, 8'h4B, 8'h74: k = KEY_RIGHT;
        default:             k = KEY_OTHER;
      endcase
    end
    return k;
  endfunction

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_ctrl(input logic [7:0] sc);
    return (sc == 8'hAA) || (sc == 8'hFA) || (sc == 8'hEE) || (sc == 8'hFE) ||
           (sc == 8'h00) || (sc == 8'hFF) || (sc == 8'hE1);
  endfunction

endpackage

// File: rtl/keyboard_fifo.sv
// First-word-fall-through event FIFO; a push while full is accepted only alongside a pop.
module keyboard_fifo
  import keyboard_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  kb_event_t din,
  input  logic      pop,
  output kb_event_t dout,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  kb_event_t       mem_q [DEPTH];
  kb_event_t       mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/keyboard_events.sv
// PS/2 scan-code decoder: E0/F0 parsing, held-key bitmap and buffered make/break events.
// Optional auto-repeat is built when KEYBOARD_REPEAT_EN is defined.
module keyboard_events
  import keyboard_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [5:0] held,
  output logic [2:0] last_key,
  output logic       ev_valid,
  output logic [2:0] ev_code,
  output logic       ev_make,
  output logic       ev_repeat,
  input  logic       ev_ready,
  output logic       overflow
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_repeat
    $error("REPEAT_DELAY and REPEAT_PERIOD must be non-zero");
  end

  state_e     state_q, state_d;
  logic [5:0] held_q, held_d;
  logic [2:0] last_key_q, last_key_d;
  logic       overflow_q, overflow_d;

  logic       dec_en, dec_make, dec_ext;
  logic [2:0] dec_code, key_idx;
  logic       par_push, rep_fire, push, pop;
  kb_event_t  push_ev, head;
  logic       fifo_full, fifo_empty;

  // Prefix parser: decides whether this byte completes a make or a break.
  always_comb begin
    state_d  = state_q;
    dec_en   = 1'b0;
    dec_make = 1'b0;
    dec_ext  = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_d = ST_EXT;
          else if (rx_data == SC_BRK) state_d = ST_BRK;
          else if (!is_ctrl(rx_data)) begin
            dec_en   = 1'b1;
            dec_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == SC_BRK) state_d = ST_EXT_BRK;
          else begin
            dec_en   = 1'b1;
            dec_make = 1'b1;
            dec_ext  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          dec_en  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          dec_en  = 1'b1;
          dec_ext = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
    dec_code = decode_key(rx_data, dec_ext);
    key_idx  = dec_code - 3'd1;
  end

  // Held bitmap and last_key; typematic duplicates of a held key are swallowed.
  always_comb begin
    held_d     = held_q;
    last_key_d = last_key_q;
    par_push   = 1'b0;
    if (dec_en) begin
      if (dec_code == KEY_OTHER) begin
        par_push = 1'b1;
      end else if (dec_make) begin
        if (!held_q[key_idx]) begin
          held_d[key_idx] = 1'b1;
          last_key_d      = dec_code;
          par_push        = 1'b1;
        end
      end else begin
        held_d[key_idx] = 1'b0;
        par_push        = 1'b1;
        if (last_key_q == dec_code) last_key_d = KEY_NONE;
      end
    end
  end

`ifdef KEYBOARD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW     = $clog2(REP_MAX + 1);

  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
  logic           rep_phase_q, rep_phase_d;

  // Phase 0 waits the initial delay, phase 1 the repeat period; parser pushes take priority.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    if (last_key_d != last_key_q) begin
      rep_cnt_d   = '0;
      rep_phase_d = 1'b0;
    end else if (last_key_q != KEY_NONE) begin
      if (rep_cnt_q == (rep_phase_q ? RCW'(REPEAT_PERIOD - 1) : RCW'(REPEAT_DELAY - 1))) begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
        rep_fire    = !par_push;
      end else begin
        rep_cnt_d = rep_cnt_q + RCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    push    = par_push || rep_fire;
    pop     = ev_ready && !fifo_empty;
    push_ev = par_push ? kb_event_t'{code: dec_code, make: dec_make, rpt: 1'b0}
                       : kb_event_t'{code: last_key_q, make: 1'b1, rpt: rep_fire};
    overflow_d = overflow_q || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      held_q     <= '0;
      last_key_q <= KEY_NONE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      last_key_q <= last_key_d;
      overflow_q <= overflow_d;
    end
  end

  keyboard_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_ev),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign held      = held_q;
  assign last_key  = last_key_q;
  assign overflow  = overflow_q;
  assign ev_valid  = !fifo_empty;
  assign ev_code   = head.code;
  assign ev_make   = head.make;
  assign ev_repeat = head.rpt;

endmodule

// File: tb/tb_keyboard_events.sv
// Bench for keyboard_events: directed scenarios plus random bytes against a queue-based model.
module tb_keyboard_events;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned RD    = 10;
  localparam int unsigned RP    = 4;

  logic       clk = 1'b0;
  logic       rst, rx_valid, ev_ready;
  logic [7:0] rx_data;
  logic [5:0] held;
  logic [2:0] last_key, ev_code;
  logic       ev_valid, ev_make, ev_repeat, overflow;

  always #5 clk = ~clk;

  keyboard_events #(.FIFO_DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .held(held), .last_key(last_key), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_make(ev_make), .ev_repeat(ev_repeat), .ev_ready(ev_ready), .overflow(overflow)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: key tables, pending prefix flags, held set and an event queue.
  int         map_n [256];
  int         map_e [256];
  bit         m_live = 1'b0;
  bit         m_ext, m_brk, m_ovf, m_first;
  bit         m_held [1:6];
  int         m_last, m_elapsed, prev_last;
  logic [4:0] m_q [$];
  bit         pp, rp, m_pop, accept;
  logic [4:0] pev;

  function automatic bit is_ctrl_b(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};
  endfunction

  function automatic void m_reset();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_first = 1; m_last = 0; m_elapsed = 0;
    for (int k = 1; k <= 6; k++) m_held[k] = 0;
    m_q.delete();
  endfunction

  function automatic void m_key(input int code, input bit make);
    logic [2:0] c;
    c = code[2:0];
    if (code >= 1 && code <= 6) begin
      if (make) begin
        if (!m_held[code]) begin
          m_held[code] = 1; m_last = code; pp = 1; pev = {c, 2'b10};
        end
      end else begin
        m_held[code] = 0;
        if (m_last == code) m_last = 0;
        pp = 1; pev = {c, 2'b00};
      end
    end else begin
      pp = 1; pev = {3'd7, make, 1'b0};
    end
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    if (!m_ext && !m_brk) begin
      if (b == 8'hE0)          m_ext = 1;
      else if (b == 8'hF0)     m_brk = 1;
      else if (!is_ctrl_b(b))  m_key(map_n[b], 1);
    end else if (!m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else begin m_key(map_e[b], 1); m_ext = 0; end
    end else begin
      m_key(m_ext ? map_e[b] : map_n[b], 0);
      m_ext = 0; m_brk = 0;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_reset();
      m_live = 1;
    end else if (m_live) begin
      m_pop = (m_q.size() > 0) && ev_ready;
      pp = 0; rp = 0; prev_last = m_last;
      if (rx_valid) m_byte(rx_data);
`ifdef KEYBOARD_REPEAT_EN
      if (prev_last != 0) begin
        m_elapsed++;
        if (m_elapsed == (m_first ? RD : RP)) begin
          m_elapsed = 0; m_first = 0; rp = !pp;
        end
      end
      if (m_last != prev_last) begin m_elapsed = 0; m_first = 1; end
`endif
      accept = 0;
      if (pp || rp) begin
        if (m_q.size() < DEPTH || m_pop) accept = 1;
        else m_ovf = 1;
      end
      if (m_pop) void'(m_q.pop_front());
      if (accept) begin
        logic [4:0] rev;
        rev = {3'(prev_last), 2'b11};
        m_q.push_back(pp ? pev : rev);
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_live) begin
      int h;
      h = 0;
      for (int k = 1; k <= 6; k++) if (m_held[k]) h |= (1 << (k - 1));
      check("mdl_ev_valid", int'(ev_valid), int'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("mdl_ev_code",   int'(ev_code),   int'(m_q[0][4:2]));
        check("mdl_ev_make",   int'(ev_make),   int'(m_q[0][1]));
        check("mdl_ev_repeat", int'(ev_repeat), int'(m_q[0][0]));
      end
      check("mdl_held",     int'(held),     h);
      check("mdl_last_key", int'(last_key), m_last);
      check("mdl_overflow", int'(overflow), int'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic chk_head(input string name, input int code, input int make, input int rpt);
    check({name, "_valid"},  int'(ev_valid),  1);
    check({name, "_code"},   int'(ev_code),   code);
    check({name, "_make"},   int'(ev_make),   make);
    check({name, "_repeat"}, int'(ev_repeat), rpt);
  endtask

  task automatic chk_reset_outputs(input string name);
    check({name, "_held"},     int'(held),     0);
    check({name, "_last_key"}, int'(last_key), 0);
    check({name, "_ev_valid"}, int'(ev_valid), 0);
    check({name, "_overflow"}, int'(overflow), 0);
  endtask

  logic [7:0] pool [24];
  int         exp_codes [4];
  int         nrep, first_rep;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ev_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin map_n[i] = 7; map_e[i] = 7; end
    map_n[8'h76] = 1; map_n[8'h29] = 2;
    map_n[8'h1D] = 3; map_n[8'h42] = 3; map_n[8'h75] = 3;
    map_n[8'h1B] = 4; map_n[8'h3B] = 4; map_n[8'h72] = 4;
    map_n[8'h1C] = 5; map_n[8'h33] = 5; map_n[8'h6B] = 5;
    map_n[8'h23] = 6; map_n[8'h4B] = 6; map_n[8'h74] = 6;
    map_e[8'h75] = 3; map_e[8'h72] = 4; map_e[8'h6B] = 5; map_e[8'h74] = 6;
    pool = '{8'hE0, 8'hF0, 8'hF0, 8'h1D, 8'h42, 8'h75, 8'h1B, 8'h3B, 8'h72, 8'h1C, 8'h33, 8'h6B,
             8'h23, 8'h4B, 8'h74, 8'h76, 8'h29, 8'h12, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hE1, 8'hE0};

    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Plain make/break of an alias of up.
    send(8'h1D);
    chk_head("up_make", 3, 1, 0);
    check("up_make_held", int'(held), 6'b000100);
    check("up_make_last", int'(last_key), 3);
    send(8'hF0);
    send(8'h1D);
    chk_head("up_break", 3, 0, 0);
    check("up_break_held", int'(held), 0);
    check("up_break_last", int'(last_key), 0);

    // Extended left, then an unknown extended code.
    send(8'hE0); send(8'h6B);
    chk_head("ext_left_make", 5, 1, 0);
    check("ext_left_held", int'(held), 6'b010000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    chk_head("ext_left_break", 5, 0, 0);
    send(8'hE0); send(8'h12);
    chk_head("ext_other", 7, 1, 0);
    check("ext_other_held", int'(held), 0);
    check("ext_other_last", int'(last_key), 0);

    // Typematic duplicates produce no events.
    send(8'h29);
    chk_head("space_make", 2, 1, 0);
    send(8'h29);
    check("space_dup1", int'(ev_valid), 0);
    send(8'h29);
    check("space_dup2", int'(ev_valid), 0);
    send(8'hF0);
    check("space_brk_prefix", int'(ev_valid), 0);
    send(8'h29);
    chk_head("space_break", 2, 0, 0);
    tick();

    // Fill past capacity with the consumer stalled.
    ev_ready = 1'b0;
    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23); send(8'h76);
    check("ovf_flag", int'(overflow), 1);
    chk_head("ovf_head", 3, 1, 0);
    repeat (3) tick();
    chk_head("ovf_head_stable", 3, 1, 0);
    exp_codes = '{3, 4, 5, 6};
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_code", int'(ev_code), exp_codes[i]);
      tick();
    end
    check("drain_empty", int'(ev_valid), 0);
    send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1B);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);
    send(8'hF0); send(8'h76);
    rst = 1'b1; tick(); rst = 1'b0; tick();

`ifdef KEYBOARD_REPEAT_EN
    // Auto-repeat of esc: first after the delay, then every period.
    send(8'h76);
    chk_head("rep_make", 1, 1, 0);
    nrep = 0; first_rep = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (ev_valid && ev_repeat) begin
        if (nrep == 0) first_rep = k;
        nrep++;
        check("rep_code", int'(ev_code), 1);
        check("rep_spacing", (k - RD) % RP, 0);
      end
    end
    check("rep_first", first_rep, 10);
    check("rep_count", nrep, 6);
    send(8'hF0); send(8'h76);
    nrep = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ev_valid && ev_repeat) nrep++;
    end
    check("rep_stopped", nrep, 0);
`endif

    // Reset right after an E0 prefix discards it.
    send(8'hE0);
    rst = 1'b1;
    tick();
    chk_reset_outputs("mid_reset");
    rst = 1'b0;
    send(8'h75);
    chk_head("post_reset_up", 3, 1, 0);
    check("post_reset_held", int'(held), 6'b000100);
    send(8'hF0); send(8'h75);
    tick();

    // Random traffic, random back-pressure and rare resets.
    for (int c = 0; c < 4000; c++) begin
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_data  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 23)];
      ev_ready = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; rx_valid = 1'b0; ev_ready = 1'b1;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
